truth_table_sequencer: RTL and testbench



---
 rtl/truth_table_sequencer_if.sv | 34 +++
 rtl/truth_table_sequencer.sv | 122 ++++++++++++
 tb/tb_truth_table_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sequencer_if.sv
// truth_table_sequencer_if: groups the sequencer's handshake and result signals.
//   start          - single-cycle sweep request (to sequencer)
//   r_a, r_b       - results of the two implementations under comparison (to sequencer)
//   x_out          - input vector driven to both implementations (from sequencer)
//   busy, done     - sweep in progress / sweep finished (from sequencer)
//   mismatch_count - vectors where r_a != r_b (from sequencer)
//   fail_flag      - at least one mismatch seen this sweep (from sequencer)
//   first_fail_vec - x_out of the first mismatch, 0 if none (from sequencer)
//   pass           - done with zero mismatches (from sequencer)
// master: the sequencer side. slave: the side holding the implementations.
interface truth_table_sequencer_if #(
   parameter int unsigned N_IN = 2
);
   logic            start;
   logic            r_a;
   logic            r_b;
   logic [N_IN-1:0] x_out;
   logic            busy;
   logic            done;
   logic [N_IN:0]   mismatch_count;
   logic            fail_flag;
   logic [N_IN-1:0] first_fail_vec;
   logic            pass;

   modport master (
      input  start, r_a, r_b,
      output x_out, busy, done, mismatch_count, fail_flag, first_fail_vec, pass
   );

   modport slave (
      output start, r_a, r_b,
      input  x_out, busy, done, mismatch_count, fail_flag, first_fail_vec, pass
   );
endinterface

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps all 2^N_IN input vectors through two implementations of
// the same Boolean function, holds each vector SETTLE cycles, samples r_a/r_b for one
// CHECK cycle and records mismatches.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high; has priority over start
//   bus   - truth_table_sequencer_if master modport (start, r_a, r_b in; results out)
// All outputs come straight from registers.
module truth_table_sequencer #(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned SETTLE = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   truth_table_sequencer_if.master bus
);

   localparam int unsigned  NumVec     = 1 << N_IN;
   localparam logic [3:0]   SettleLast = 4'(SETTLE - 1);
   localparam logic [3:0]   SettleOne  = 4'd1;
   localparam logic [N_IN:0]   CntOne  = (N_IN + 1)'(1);
   localparam logic [N_IN:0]   CntMax  = (N_IN + 1)'(NumVec);
   localparam logic [N_IN-1:0] VecOne  = N_IN'(1);

   typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

   state_e          state_q, state_d;
   logic [3:0]      settle_cnt_q, settle_cnt_d;
   logic [N_IN-1:0] x_q, x_d;
   logic [N_IN-1:0] first_q, first_d;
   logic [N_IN:0]   cnt_q, cnt_d;
   logic            fail_q, fail_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;

   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      x_d          = x_q;
      first_d      = first_q;
      cnt_d        = cnt_q;
      fail_d       = fail_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d      = StSettle;
               settle_cnt_d = '0;
               x_d          = '0;
               first_d      = '0;
               cnt_d        = '0;
               fail_d       = 1'b0;
            end
         end
         StSettle: begin
            settle_cnt_d = settle_cnt_q + SettleOne;
            if (settle_cnt_q == SettleLast) begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (bus.r_a != bus.r_b) begin
               if (cnt_q != CntMax) begin
                  cnt_d = cnt_q + CntOne;
               end
               if (!fail_q) begin
                  fail_d  = 1'b1;
                  first_d = x_q;
               end
            end
            // The all-ones vector is the last one; x_out holds rather than wrapping.
            if (x_q == '1) begin
               state_d = StDone;
            end else begin
               x_d          = x_q + VecOne;
               settle_cnt_d = '0;
               state_d      = StSettle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Status flags are computed from next state so they can be registered.
      busy_d = (state_d == StSettle) || (state_d == StCheck);
      done_d = (state_d == StDone);
      pass_d = done_d && (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         settle_cnt_q <= '0;
         x_q          <= '0;
         first_q      <= '0;
         cnt_q        <= '0;
         fail_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         x_q          <= x_d;
         first_q      <= first_d;
         cnt_q        <= cnt_d;
         fail_q       <= fail_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   assign bus.x_out          = x_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.mismatch_count = cnt_q;
   assign bus.fail_flag      = fail_q;
   assign bus.first_fail_vec = first_q;
   assign bus.pass           = pass_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: drives two sequencers (SETTLE=1 and SETTLE=3, both N_IN=2)
// whose r_a/r_b come from bench-held truth tables indexed by x_out. Expected results come
// from a counting model over the truth tables and from a table of hand-derived records.
module tb_truth_table_sequencer;

   localparam int unsigned N  = 2;
   localparam int unsigned NV = 1 << N;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   truth_table_sequencer_if #(.N_IN(N)) bus1 ();
   truth_table_sequencer_if #(.N_IN(N)) bus3 ();

   truth_table_sequencer #(.N_IN(N), .SETTLE(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.master)
   );

   truth_table_sequencer #(.N_IN(N), .SETTLE(3)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3.master)
   );

   logic [NV-1:0] ta1, tb1, ta3, tb3;
   logic          glitch3;

   assign bus1.r_a = ta1[bus1.x_out];
   assign bus1.r_b = tb1[bus1.x_out];
   assign bus3.r_a = ta3[bus3.x_out];
   assign bus3.r_b = tb3[bus3.x_out] ^ glitch3;

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: among the first nchk vectors, count differences and find the first one.
   task automatic model(input logic [NV-1:0] a, input logic [NV-1:0] b, input int nchk,
                        output int cnt, output int first, output bit seen);
      cnt   = 0;
      first = 0;
      seen  = 1'b0;
      for (int v = 0; v < nchk; v++) begin
         if (a[v] != b[v]) begin
            cnt++;
            if (!seen) begin
               seen  = 1'b1;
               first = v;
            end
         end
      end
   endtask

   // Full sweep on the SETTLE=1 instance, checked every cycle. With SETTLE=1 each vector
   // spans 2 cycles, so after accept-edge k the current vector is k/2 and k/2 vectors have
   // been sampled. Optional extra start pulses land on edges 3 and 6.
   task automatic sweep1(input logic [NV-1:0] a, input logic [NV-1:0] b, input bit extra);
      int cnt, first;
      bit seen;
      ta1 = a;
      tb1 = b;
      bus1.start = 1'b1;
      tick();
      for (int k = 0; k < int'(NV) * 2; k++) begin
         model(a, b, k / 2, cnt, first, seen);
         chk("sweep_x_out", bus1.x_out, k / 2);
         chk("sweep_busy", bus1.busy, 1);
         chk("sweep_done", bus1.done, 0);
         chk("sweep_count", bus1.mismatch_count, cnt);
         chk("sweep_fail", bus1.fail_flag, seen);
         chk("sweep_first", bus1.first_fail_vec, first);
         bus1.start = extra && (k == 2 || k == 5);
         tick();
      end
      bus1.start = 1'b0;
      model(a, b, NV, cnt, first, seen);
      chk("end_done", bus1.done, 1);
      chk("end_busy", bus1.busy, 0);
      chk("end_x_out", bus1.x_out, NV - 1);
      chk("end_count", bus1.mismatch_count, cnt);
      chk("end_fail", bus1.fail_flag, seen);
      chk("end_first", bus1.first_fail_vec, first);
      chk("end_pass", bus1.pass, cnt == 0);
      tick();
      chk("hold_done", bus1.done, 1);
      chk("hold_count", bus1.mismatch_count, cnt);
      chk("hold_x_out", bus1.x_out, NV - 1);
   endtask

   typedef struct {
      string         name;
      logic [NV-1:0] ta;
      logic [NV-1:0] tb;
      bit            extra;
      int            exp_cnt;
      int            exp_first;
      bit            exp_fail;
      bit            exp_pass;
   } vec_t;

   // f = x | ~y with x = x_out[1], y = x_out[0]: vectors 00,01,10,11 -> 1,0,1,1.
   localparam logic [NV-1:0] FOrY = 4'b1101;

   vec_t tbl[5];

   initial begin
      int cnt, first;
      bit seen;
      logic [NV-1:0] ra, rb;

      tbl[0] = '{"equivalent",   FOrY, FOrY,            1'b0, 0, 0, 1'b0, 1'b1};
      tbl[1] = '{"single_fault", FOrY, FOrY ^ 4'b0100,  1'b0, 1, 2, 1'b1, 1'b0};
      tbl[2] = '{"all_fault",    FOrY, ~FOrY,           1'b0, 4, 0, 1'b1, 1'b0};
      tbl[3] = '{"extra_starts", FOrY, FOrY,            1'b1, 0, 0, 1'b0, 1'b1};
      tbl[4] = '{"late_faults",  FOrY, FOrY ^ 4'b1010,  1'b1, 2, 1, 1'b1, 1'b0};

      reset      = 1'b1;
      bus1.start = 1'b0;
      bus3.start = 1'b0;
      glitch3    = 1'b0;
      ta1 = FOrY; tb1 = FOrY; ta3 = FOrY; tb3 = FOrY;
      tick();
      tick();
      chk("rst_x_out", bus1.x_out, 0);
      chk("rst_busy", bus1.busy, 0);
      chk("rst_done", bus1.done, 0);
      chk("rst_count", bus1.mismatch_count, 0);
      chk("rst_fail", bus1.fail_flag, 0);
      chk("rst_first", bus1.first_fail_vec, 0);
      chk("rst_pass", bus1.pass, 0);
      chk("rst3_busy", bus3.busy, 0);

      // Reset wins over start.
      bus1.start = 1'b1;
      tick();
      chk("rst_prio_busy", bus1.busy, 0);
      bus1.start = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      chk("idle_busy", bus1.busy, 0);
      chk("idle_done", bus1.done, 0);

      // Table-driven sweeps, back to back so each later start is taken from DONE.
      for (int i = 0; i < 5; i++) begin
         sweep1(tbl[i].ta, tbl[i].tb, tbl[i].extra);
         chk({"tbl_count_", tbl[i].name}, bus1.mismatch_count, tbl[i].exp_cnt);
         chk({"tbl_first_", tbl[i].name}, bus1.first_fail_vec, tbl[i].exp_first);
         chk({"tbl_fail_", tbl[i].name}, bus1.fail_flag, tbl[i].exp_fail);
         chk({"tbl_pass_", tbl[i].name}, bus1.pass, tbl[i].exp_pass);
      end

      // Reset mid-sweep: all-fault tables, reset sampled at edge 5.
      ta1 = FOrY;
      tb1 = ~FOrY;
      bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("midrst_pre_count", bus1.mismatch_count, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_x_out", bus1.x_out, 0);
      chk("midrst_busy", bus1.busy, 0);
      chk("midrst_count", bus1.mismatch_count, 0);
      chk("midrst_fail", bus1.fail_flag, 0);
      tick();
      chk("midrst_idle", bus1.busy, 0);
      sweep1(FOrY, FOrY, 1'b0);

      // Randomized truth tables against the model.
      for (int i = 0; i < 12; i++) begin
         ra = NV'($urandom);
         rb = NV'($urandom);
         sweep1(ra, rb, 1'($urandom));
      end

      // SETTLE=3: vector held 3 cycles then one CHECK; r_b glitches in every settle cycle.
      ta3 = FOrY;
      tb3 = FOrY;
      bus3.start = 1'b1;
      tick();
      bus3.start = 1'b0;
      for (int k = 0; k < int'(NV) * 4; k++) begin
         chk("s3_x_out", bus3.x_out, k / 4);
         chk("s3_busy", bus3.busy, 1);
         chk("s3_done", bus3.done, 0);
         chk("s3_count", bus3.mismatch_count, 0);
         glitch3 = (k % 4) != 3;
         tick();
      end
      glitch3 = 1'b0;
      chk("s3_end_done", bus3.done, 1);
      chk("s3_end_count", bus3.mismatch_count, 0);
      chk("s3_end_pass", bus3.pass, 1);

      // SETTLE=3 with a fault on vector 11 only.
      tb3 = FOrY ^ 4'b1000;
      bus3.start = 1'b1;
      tick();
      bus3.start = 1'b0;
      for (int k = 0; k < int'(NV) * 4; k++) tick();
      model(ta3, tb3, NV, cnt, first, seen);
      chk("s3f_done", bus3.done, 1);
      chk("s3f_count", bus3.mismatch_count, cnt);
      chk("s3f_first", bus3.first_fail_vec, first);
      chk("s3f_fail", bus3.fail_flag, seen);
      chk("s3f_pass", bus3.pass, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
